// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S stereo transmitter with a single-pair holding register
// Optional build macro I2S_TX_UNDERRUN_HOLD_EN: repeat the last pair on underrun instead of sending zeros.
module i2s_tx #(
   parameter int WIDTH_data = 24,
   parameter int SLOT       = 32,
   parameter int BCLK_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH_data-1:0] data_l,
   input  logic [WIDTH_data-1:0] data_r,
   output logic                  bclk,
   output logic                  lrclk,
   output logic                  sdata,
   output logic                  underrun
);

   localparam int DW = $clog2(BCLK_DIV);
   localparam int BW = $clog2(2 * SLOT);

   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
   localparam logic [BW-1:0] B_LAST   = BW'(2 * SLOT - 1);
   localparam logic [BW-1:0] B_SLOT   = BW'(SLOT);
   localparam logic [BW-1:0] L_BEG    = BW'(1);
   localparam logic [BW-1:0] L_END    = BW'(WIDTH_data);
   localparam logic [BW-1:0] R_BEG    = BW'(SLOT + 1);
   localparam logic [BW-1:0] R_END    = BW'(SLOT + WIDTH_data);

   logic [DW-1:0]         div_q, div_d;
   logic [BW-1:0]         b_q, b_d;
   logic                  bclk_q, bclk_d;
   logic                  lrclk_q, lrclk_d;
   logic                  sdata_q, sdata_d;
   logic                  underrun_q, underrun_d;
   logic                  in_ready_q, in_ready_d;
   logic                  hold_full_q, hold_full_d;
   logic [WIDTH_data-1:0] hold_l_q, hold_l_d;
   logic [WIDTH_data-1:0] hold_r_q, hold_r_d;
   logic [WIDTH_data-1:0] sh_l_q, sh_l_d;
   logic [WIDTH_data-1:0] sh_r_q, sh_r_d;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
   logic [WIDTH_data-1:0] last_l_q, last_l_d;
   logic [WIDTH_data-1:0] last_r_q, last_r_d;
`endif

   logic fall;
   logic frame_start;
   logic accept;

   always_comb begin
      div_d       = div_q;
      b_d         = b_q;
      lrclk_d     = lrclk_q;
      sdata_d     = sdata_q;
      underrun_d  = 1'b0;
      hold_full_d = hold_full_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      sh_l_d      = sh_l_q;
      sh_r_d      = sh_r_q;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      last_l_d    = last_l_q;
      last_r_d    = last_r_q;
`endif

      fall        = (div_q == DIV_LAST);
      frame_start = fall && (b_q == B_LAST);
      accept      = in_valid && in_ready_q;

      div_d  = fall ? '0 : div_q + 1'b1;
      bclk_d = (div_d >= DIV_HALF);

      // Every serial output moves together on the bclk falling edge event.
      if (fall) begin
         b_d     = frame_start ? '0 : b_q + 1'b1;
         lrclk_d = (b_d >= B_SLOT);
         sdata_d = 1'b0;
         if (frame_start) begin
            if (hold_full_q) begin
               sh_l_d      = hold_l_q;
               sh_r_d      = hold_r_q;
               hold_full_d = 1'b0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
               last_l_d    = hold_l_q;
               last_r_d    = hold_r_q;
`endif
            end else begin
               underrun_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
               sh_l_d     = last_l_q;
               sh_r_d     = last_r_q;
`else
               sh_l_d     = '0;
               sh_r_d     = '0;
`endif
            end
         end else if (b_d >= L_BEG && b_d <= L_END) begin
            sdata_d = sh_l_q[WIDTH_data-1];
            sh_l_d  = {sh_l_q[WIDTH_data-2:0], 1'b0};
         end else if (b_d >= R_BEG && b_d <= R_END) begin
            sdata_d = sh_r_q[WIDTH_data-1];
            sh_r_d  = {sh_r_q[WIDTH_data-2:0], 1'b0};
         end
      end

      // Accept only when empty, so it can never coincide with a frame-start copy.
      if (accept) begin
         hold_full_d = 1'b1;
         hold_l_d    = data_l;
         hold_r_d    = data_r;
      end

      in_ready_d = !hold_full_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q       <= '0;
         b_q         <= '0;
         bclk_q      <= 1'b0;
         lrclk_q     <= 1'b0;
         sdata_q     <= 1'b0;
         underrun_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         hold_full_q <= 1'b0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         sh_l_q      <= '0;
         sh_r_q      <= '0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
         last_l_q    <= '0;
         last_r_q    <= '0;
`endif
      end else begin
         div_q       <= div_d;
         b_q         <= b_d;
         bclk_q      <= bclk_d;
         lrclk_q     <= lrclk_d;
         sdata_q     <= sdata_d;
         underrun_q  <= underrun_d;
         in_ready_q  <= in_ready_d;
         hold_full_q <= hold_full_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         sh_l_q      <= sh_l_d;
         sh_r_q      <= sh_r_d;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
         last_l_q    <= last_l_d;
         last_r_q    <= last_r_d;
`endif
      end
   end

   assign bclk     = bclk_q;
   assign lrclk    = lrclk_q;
   assign sdata    = sdata_q;
   assign underrun = underrun_q;
   assign in_ready = in_ready_q;

endmodule
